// File: rtl/timer_digit_entry.sv
// Keypad front-end for the microwave timer: shifts decimal key presses into an MM:SS BCD
// buffer, validates it, and hands it to the down-counter chain with a one-cycle loadn strobe.
//
// state  | meaning
// IDLE   | buffer empty, waiting for the first digit
// ENTRY  | one or more digits held, editable
// LOAD   | loadn driven low for this single cycle
// LOCKED | counters own the digits; wait for timer_running to fall
module timer_digit_entry #(
  parameter int NUM_DIGITS = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [9:0]              keypad,
  input  logic                    clear_key,
  input  logic                    start_key,
  input  logic                    timer_running,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic                    loadn,
  output logic                    entry_valid,
  output logic                    key_error
);

  localparam int DW = 4 * NUM_DIGITS;
  localparam int CW = $clog2(NUM_DIGITS + 1);
  localparam logic [CW-1:0] FULL = CW'(NUM_DIGITS);

  typedef enum logic [1:0] {IDLE, ENTRY, LOAD, LOCKED} state_t;

  state_t          state_q, state_d;
  logic [DW-1:0]   digits_q, digits_d;
  logic [CW-1:0]   count_q, count_d;
  logic            loadn_q, loadn_d;
  logic            key_error_q, key_error_d;
  logic [9:0]      kp_q, kp_d, kp_prev_q, kp_prev_d;
  logic            clr_q, clr_d, clr_prev_q, clr_prev_d;
  logic            st_q, st_d, st_prev_q, st_prev_d;
  logic            tr_q, tr_d;

  logic            kp_event, clr_event, st_event, tr_fall;
  logic            valid;

  function automatic logic [3:0] key_to_bcd(input logic [9:0] k);
    logic [3:0] b;
    b = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (k[i]) b = 4'(i);
    end
    return b;
  endfunction

  assign valid = (count_q != '0) && (digits_q != '0) && (digits_q[7:4] <= 4'd5);

  always_comb begin
    // Keypad keys form one group: a new digit event needs every digit key released.
    kp_event  = (kp_q != '0) && (kp_prev_q == '0);
    clr_event = clr_q & ~clr_prev_q;
    st_event  = st_q & ~st_prev_q;
    tr_fall   = tr_q & ~timer_running;

    state_d     = state_q;
    digits_d    = digits_q;
    count_d     = count_q;
    loadn_d     = 1'b1;
    key_error_d = 1'b0;
    kp_d        = keypad;
    kp_prev_d   = kp_q;
    clr_d       = clear_key;
    clr_prev_d  = clr_q;
    st_d        = start_key;
    st_prev_d   = st_q;
    tr_d        = timer_running;

    case (state_q)
      IDLE, ENTRY: begin
        if (clr_event) begin
          digits_d = '0;
          count_d  = '0;
          state_d  = IDLE;
        end else if (!timer_running) begin
          if (st_event) begin
            if (state_q == ENTRY && valid) begin
              state_d = LOAD;
              loadn_d = 1'b0;
            end else begin
              key_error_d = 1'b1;
            end
          end else if (kp_event) begin
            if (!$onehot(kp_q)) begin
              key_error_d = 1'b1;
            end else if (count_q < FULL) begin
              digits_d = {digits_q[DW-5:0], key_to_bcd(kp_q)};
              count_d  = count_q + CW'(1);
              state_d  = ENTRY;
            end
          end
        end
      end
      LOAD: begin
        state_d = LOCKED;
      end
      LOCKED: begin
        if (tr_fall) begin
          digits_d = '0;
          count_d  = '0;
          state_d  = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      digits_q    <= '0;
      count_q     <= '0;
      loadn_q     <= 1'b1;
      key_error_q <= 1'b0;
      kp_q        <= '0;
      kp_prev_q   <= '0;
      clr_q       <= 1'b0;
      clr_prev_q  <= 1'b0;
      st_q        <= 1'b0;
      st_prev_q   <= 1'b0;
      tr_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      digits_q    <= digits_d;
      count_q     <= count_d;
      loadn_q     <= loadn_d;
      key_error_q <= key_error_d;
      kp_q        <= kp_d;
      kp_prev_q   <= kp_prev_d;
      clr_q       <= clr_d;
      clr_prev_q  <= clr_prev_d;
      st_q        <= st_d;
      st_prev_q   <= st_prev_d;
      tr_q        <= tr_d;
    end
  end

  assign digits      = digits_q;
  assign loadn       = loadn_q;
  assign entry_valid = valid;
  assign key_error   = key_error_q;

endmodule

// File: tb/tb_timer_digit_entry.sv
// Directed bench for timer_digit_entry: key entry, validation, load strobe, lock and reset.
module tb_timer_digit_entry;

  logic        clock = 1'b0;
  logic        reset;
  logic [9:0]  keypad;
  logic        clear_key;
  logic        start_key;
  logic        timer_running;
  logic [15:0] digits;
  logic        loadn;
  logic        entry_valid;
  logic        key_error;

  int compared   = 0;
  int mismatched = 0;
  int err_cnt;
  int low_cnt;

  timer_digit_entry #(.NUM_DIGITS(4)) dut (
    .clock        (clock),
    .reset        (reset),
    .keypad       (keypad),
    .clear_key    (clear_key),
    .start_key    (start_key),
    .timer_running(timer_running),
    .digits       (digits),
    .loadn        (loadn),
    .entry_valid  (entry_valid),
    .key_error    (key_error)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Hold the given inputs 2 cycles, release for 3; count key_error pulses and loadn lows.
  task automatic drive(input logic [9:0] kp, input logic clr, input logic st,
                       output int errs, output int lows);
    errs = 0;
    lows = 0;
    keypad = kp; clear_key = clr; start_key = st;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        keypad = '0; clear_key = 1'b0; start_key = 1'b0;
      end
      tick();
      if (key_error) errs++;
      if (!loadn) lows++;
    end
  endtask

  task automatic press(input int k);
    int e, l;
    drive(10'(1 << k), 1'b0, 1'b0, e, l);
  endtask

  task automatic do_clear();
    int e, l;
    drive('0, 1'b1, 1'b0, e, l);
  endtask

  initial begin
    reset = 1'b1; keypad = '0; clear_key = 1'b0; start_key = 1'b0; timer_running = 1'b0;
    tick(); tick(); tick();
    reset = 1'b0;
    chk("rst_digits", 32'(digits), 32'h0);
    chk("rst_loadn", 32'(loadn), 32'h1);
    chk("rst_valid", 32'(entry_valid), 32'h0);
    chk("rst_err", 32'(key_error), 32'h0);

    // start on empty buffer
    drive('0, 1'b0, 1'b1, err_cnt, low_cnt);
    chk("idle_start_err", 32'(err_cnt), 32'd1);
    chk("idle_start_loadn", 32'(low_cnt), 32'd0);

    // reset held 2 cycles mid-entry
    press(5);
    chk("pre_rst_digits", 32'(digits), 32'h0005);
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    chk("mid_rst_digits", 32'(digits), 32'h0);
    chk("mid_rst_loadn", 32'(loadn), 32'h1);
    chk("mid_rst_valid", 32'(entry_valid), 32'h0);
    chk("mid_rst_err", 32'(key_error), 32'h0);

    // latency and held key
    keypad = 10'(1 << 1);
    tick();
    chk("lat_edge1", 32'(digits), 32'h0000);
    tick();
    chk("lat_edge2", 32'(digits), 32'h0001);
    for (int i = 0; i < 18; i++) tick();
    chk("held_single", 32'(digits), 32'h0001);
    keypad = '0;
    tick(); tick();
    press(3);
    press(0);
    chk("entry_0130", 32'(digits), 32'h0130);
    chk("valid_0130", 32'(entry_valid), 32'h1);

    // buffer full
    do_clear();
    chk("clear_digits", 32'(digits), 32'h0);
    chk("clear_valid", 32'(entry_valid), 32'h0);
    press(1); press(2); press(3); press(4);
    drive(10'(1 << 5), 1'b0, 1'b0, err_cnt, low_cnt);
    chk("full_digits", 32'(digits), 32'h1234);
    chk("full_no_err", 32'(err_cnt), 32'd0);

    // invalid seconds tens, then multi-key
    do_clear();
    press(1); press(9); press(0);
    chk("entry_0190", 32'(digits), 32'h0190);
    chk("valid_0190", 32'(entry_valid), 32'h0);
    drive('0, 1'b0, 1'b1, err_cnt, low_cnt);
    chk("bad_start_err", 32'(err_cnt), 32'd1);
    chk("bad_start_loadn", 32'(low_cnt), 32'd0);
    chk("bad_start_digits", 32'(digits), 32'h0190);
    drive(10'((1 << 3) | (1 << 7)), 1'b0, 1'b0, err_cnt, low_cnt);
    chk("multi_err", 32'(err_cnt), 32'd1);
    chk("multi_digits", 32'(digits), 32'h0190);
    press(0);
    chk("still_entry", 32'(digits), 32'h1900);
    chk("valid_1900", 32'(entry_valid), 32'h1);

    // good load
    do_clear();
    press(1); press(3); press(0);
    start_key = 1'b1;
    low_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      if (i == 2) start_key = 1'b0;
      tick();
      if (!loadn) low_cnt++;
      chk("load_digits_stable", 32'(digits), 32'h0130);
    end
    chk("load_low_cycles", 32'(low_cnt), 32'd1);
    timer_running = 1'b1;
    tick(); tick();
    press(9);
    chk("locked_key", 32'(digits), 32'h0130);
    drive('0, 1'b1, 1'b0, err_cnt, low_cnt);
    chk("locked_clear", 32'(digits), 32'h0130);
    chk("locked_no_err", 32'(err_cnt), 32'd0);
    timer_running = 1'b0;
    tick(); tick(); tick();
    chk("run_end_digits", 32'(digits), 32'h0);
    chk("run_end_valid", 32'(entry_valid), 32'h0);
    press(2);
    chk("idle_after_run", 32'(digits), 32'h0002);

    // same-cycle priority
    drive(10'(1 << 4), 1'b1, 1'b0, err_cnt, low_cnt);
    chk("clear_beats_digit", 32'(digits), 32'h0);
    press(1); press(2);
    chk("entry_0012", 32'(digits), 32'h0012);
    drive(10'(1 << 4), 1'b0, 1'b1, err_cnt, low_cnt);
    chk("start_beats_digit", 32'(digits), 32'h0012);
    chk("start_digit_load", 32'(low_cnt), 32'd1);
    timer_running = 1'b1;
    tick(); tick();
    timer_running = 1'b0;
    tick(); tick(); tick();
    chk("exit_lock", 32'(digits), 32'h0);

    // reset during LOAD
    press(1); press(2);
    start_key = 1'b1;
    tick(); tick();
    chk("in_load_loadn", 32'(loadn), 32'h0);
    reset = 1'b1;
    tick();
    chk("rst_load_loadn", 32'(loadn), 32'h1);
    chk("rst_load_digits", 32'(digits), 32'h0);
    reset = 1'b0;
    start_key = 1'b0;
    tick(); tick();
    chk("post_rst_loadn", 32'(loadn), 32'h1);
    chk("post_rst_err", 32'(key_error), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
